asg_target_table_generator: RTL and testbench
=============================================

ASG_TARGET_TABLE_GENERATOR -- requirements
Module: asg_target_table_generator

Interface
REQ-001 The block SHALL have parameter NUM_TARGETS, default 8, number of target table entries.
REQ-002 The block SHALL have parameter RANGE_BINS, default 3200, number of 1-usec range bins per sweep.
REQ-003 The block SHALL have parameter WIDTH_W, default 4, pulse-width field width in bits (usec).
REQ-004 The block SHALL derive localparams BIN_W = clog2(RANGE_BINS) and ADDR_W = clog2(NUM_TARGETS).
REQ-005 The block SHALL have port SYS_CLK, input, 1 bit, the single system clock (100 MHz).
REQ-006 The block SHALL have port SYS_RESETN, input, 1 bit, the reset; it is asynchronous and active-low.
REQ-007 The block SHALL have port RADAR_TRIG_PE, input, 1 bit, one-cycle radar trigger pulse that starts a sweep.
REQ-008 The block SHALL have port USEC_PE, input, 1 bit, one-cycle microsecond tick that advances the bin.
REQ-009 The block SHALL have port EN, input, 1 bit, generator enable.
REQ-010 The block SHALL have port CFG_WE, input, 1 bit, shadow table write strobe.
REQ-011 The block SHALL have port CFG_ADDR, input, ADDR_W bits, shadow entry index.
REQ-012 The block SHALL have port CFG_START, input, BIN_W bits, target start bin.
REQ-013 The block SHALL have port CFG_WIDTH, input, WIDTH_W bits, pulse width in bins; 0 disables the entry.
REQ-014 The block SHALL have port CFG_COMMIT, input, 1 bit, request to copy shadow to active at the next trigger.
REQ-015 The block SHALL have port GEN_SIGNAL, output, 1 bit, generated video.
REQ-016 The block SHALL have port SWEEP_ACTIVE, output, 1 bit, high while in SWEEP.
REQ-017 The block SHALL have port BIN_CNT, output, BIN_W bits, current range bin.
REQ-018 The block SHALL have port COMMIT_PENDING, output, 1 bit, commit requested but not yet applied.
REQ-019 The block SHALL have port RETRIG, output, 1 bit, one-cycle pulse when a trigger arrives during SWEEP.

Function
REQ-020 The FSM SHALL have states IDLE and SWEEP.
REQ-021 In IDLE, RADAR_TRIG_PE with EN=1 SHALL enter SWEEP with BIN_CNT=0.
REQ-022 In SWEEP, each USEC_PE SHALL increment BIN_CNT; USEC_PE at BIN_CNT=RANGE_BINS-1 SHALL return to IDLE with BIN_CNT=0.
REQ-023 In SWEEP, RADAR_TRIG_PE SHALL restart at BIN_CNT=0 and pulse RETRIG; trigger SHALL win over a simultaneous USEC_PE.
REQ-024 EN=0 SHALL force IDLE, BIN_CNT=0 and GEN_SIGNAL=0 on the next clock; triggers SHALL be ignored.
REQ-025 GEN_SIGNAL SHALL be registered high, one SYS_CLK after BIN_CNT changes, while SWEEP and any active entry has WIDTH!=0 and START<=BIN_CNT<START+WIDTH.
REQ-026 START+WIDTH SHALL be computed at BIN_W+1 bits; pulses past RANGE_BINS-1 SHALL be truncated, never wrapped.
REQ-027 Overlapping entries SHALL be OR-ed.
REQ-028 CFG_WE SHALL write the shadow entry at CFG_ADDR at any time without disturbing the active table.
REQ-029 CFG_COMMIT SHALL set COMMIT_PENDING; an accepted trigger SHALL copy shadow to active and clear COMMIT_PENDING in the same cycle.
REQ-030 When CFG_COMMIT coincides with an accepted trigger, the copy SHALL apply to that sweep.
REQ-031 When CFG_WE coincides with that copy, the written data SHALL be included.

Reset
REQ-032 SYS_RESETN low SHALL asynchronously force IDLE and zero BIN_CNT, GEN_SIGNAL, SWEEP_ACTIVE, COMMIT_PENDING, RETRIG and both tables.
REQ-033 Reset mid-sweep SHALL abort it; operation SHALL resume only on the next trigger after release.

Configuration
REQ-034 Macro ASG_TT_BLANKING_EN defined SHALL add parameter BLANK_BINS, default 10, and force GEN_SIGNAL=0 for BIN_CNT<BLANK_BINS.
REQ-035 Without ASG_TT_BLANKING_EN there SHALL be no blanking and no BLANK_BINS parameter.

Structure
REQ-036 Package asg_pkg SHALL hold the default constants and an entry typedef (start, width).
REQ-037 Sub-module asg_target_cmp SHALL implement one entry's window compare; it SHALL be instantiated NUM_TARGETS times.

Verification
REQ-038 Entries (100,3),(500,3),...,(2900,3), commit, trigger -> GEN_SIGNAL high exactly during bins 100-102, 500-502, ..., 2902; sweep ends after bin 3199.
REQ-039 Entry (3198,4) -> high during bins 3198-3199 only; low after returning to IDLE.
REQ-040 Trigger at bin 1500 -> RETRIG pulse, BIN_CNT=0; trigger coincident with USEC_PE -> BIN_CNT=0.
REQ-041 Shadow write (200,2) mid-sweep without commit -> no pulse at 200; commit plus next trigger -> pulse at bins 200-201; COMMIT_PENDING 1 then 0.
REQ-042 SYS_RESETN low at bin 800 -> all outputs 0 immediately; no sweep until the next trigger.
REQ-043 With ASG_TT_BLANKING_EN, entry (5,10) -> high only during bins 10-14.

Source files
------------

// File: rtl/asg_pkg.sv
// rtl/asg_pkg.sv - default constants and target entry type for the target table generator
package asg_pkg;

   localparam int ASG_NUM_TARGETS = 8;
   localparam int ASG_RANGE_BINS  = 3200;
   localparam int ASG_WIDTH_W     = 4;
   localparam int ASG_BLANK_BINS  = 10;
   localparam int ASG_BIN_W       = $clog2(ASG_RANGE_BINS);
   localparam int ASG_ADDR_W      = $clog2(ASG_NUM_TARGETS);

   // Entry fields are sized for the largest supported configuration so one
   // typedef serves every parameterisation; unused upper bits stay zero.
   localparam int ASG_START_FW = 16;
   localparam int ASG_WIDTH_FW = 8;

   typedef struct packed {
      logic [ASG_START_FW-1:0] start;
      logic [ASG_WIDTH_FW-1:0] width;
   } asg_entry_t;

endpackage

// File: rtl/asg_target_table_generator_if.sv
// rtl/asg_target_table_generator_if.sv - shadow table configuration bus
interface asg_target_table_generator_if #(
   parameter int ADDR_W  = asg_pkg::ASG_ADDR_W,
   parameter int BIN_W   = asg_pkg::ASG_BIN_W,
   parameter int WIDTH_W = asg_pkg::ASG_WIDTH_W
);

   logic               CFG_WE;
   logic [ADDR_W-1:0]  CFG_ADDR;
   logic [BIN_W-1:0]   CFG_START;
   logic [WIDTH_W-1:0] CFG_WIDTH;
   logic               CFG_COMMIT;

   modport master (
      output CFG_WE, CFG_ADDR, CFG_START, CFG_WIDTH, CFG_COMMIT
   );

   modport slave (
      input CFG_WE, CFG_ADDR, CFG_START, CFG_WIDTH, CFG_COMMIT
   );

endinterface

// File: rtl/asg_target_cmp.sv
// rtl/asg_target_cmp.sv - single target entry range window compare
module asg_target_cmp
   import asg_pkg::*;
#(
   parameter int BIN_W   = ASG_BIN_W,
   parameter int WIDTH_W = ASG_WIDTH_W
) (
   input  asg_entry_t       entry,
   input  logic [BIN_W-1:0] bin,
   output logic             hit
);

   localparam int EXT_W = BIN_W + 1;

   logic [BIN_W-1:0]   start_v;
   logic [WIDTH_W-1:0] width_v;
   logic [EXT_W-1:0]   start_x;
   logic [EXT_W-1:0]   end_x;
   logic [EXT_W-1:0]   bin_x;

   // Window end is formed one bit wider so a pulse near the sweep end is
   // truncated by the bin counter range instead of wrapping to low bins.
   always_comb begin
      start_v = BIN_W'(entry.start);
      width_v = WIDTH_W'(entry.width);
      start_x = {1'b0, start_v};
      bin_x   = {1'b0, bin};
      end_x   = start_x + EXT_W'(width_v);
      hit     = (width_v != '0) && (bin_x >= start_x) && (bin_x < end_x);
   end

endmodule

// File: rtl/asg_target_table_generator.sv
// rtl/asg_target_table_generator.sv - radar target video generator; ASG_TT_BLANKING_EN adds near-range blanking
module asg_target_table_generator
   import asg_pkg::*;
#(
   parameter int NUM_TARGETS = ASG_NUM_TARGETS,
   parameter int RANGE_BINS  = ASG_RANGE_BINS,
   parameter int WIDTH_W     = ASG_WIDTH_W,
`ifdef ASG_TT_BLANKING_EN
   parameter int BLANK_BINS  = ASG_BLANK_BINS,
`endif
   localparam int BIN_W      = $clog2(RANGE_BINS),
   localparam int ADDR_W     = $clog2(NUM_TARGETS)
) (
   input  logic                          SYS_CLK,
   input  logic                          SYS_RESETN,
   input  logic                          RADAR_TRIG_PE,
   input  logic                          USEC_PE,
   input  logic                          EN,
   asg_target_table_generator_if.slave   cfg,
   output logic                          GEN_SIGNAL,
   output logic                          SWEEP_ACTIVE,
   output logic [BIN_W-1:0]              BIN_CNT,
   output logic                          COMMIT_PENDING,
   output logic                          RETRIG
);

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_SWEEP = 1'b1;

   logic [0:0]             state;
   asg_entry_t             shadow_tbl [NUM_TARGETS];
   asg_entry_t             active_tbl [NUM_TARGETS];
   asg_entry_t             new_entry;
   logic [NUM_TARGETS-1:0] hits;
   logic                   any_hit;
   logic                   trig_ok;
   logic                   copy_now;
   logic                   last_bin;
   logic                   gen_next;

   assign SWEEP_ACTIVE = (state == ST_SWEEP);

   // Decode the config bus and the trigger-side events used by several blocks.
   always_comb begin
      new_entry       = '0;
      new_entry.start = ASG_START_FW'(cfg.CFG_START);
      new_entry.width = ASG_WIDTH_FW'(cfg.CFG_WIDTH);
      trig_ok         = EN && RADAR_TRIG_PE;
      copy_now        = trig_ok && (COMMIT_PENDING || cfg.CFG_COMMIT);
      last_bin        = (BIN_CNT == BIN_W'(RANGE_BINS - 1));
      any_hit         = |hits;
   end

   // One window comparator per active table entry; overlapping hits are OR-ed.
   for (genvar g = 0; g < NUM_TARGETS; g++) begin : g_cmp
      asg_target_cmp #(
         .BIN_W   (BIN_W),
         .WIDTH_W (WIDTH_W)
      ) u_cmp (
         .entry (active_tbl[g]),
         .bin   (BIN_CNT),
         .hit   (hits[g])
      );
   end

   // Video is valid only while sweeping and enabled; optional near-range blanking.
   always_comb begin
      gen_next = EN && (state == ST_SWEEP) && any_hit;
`ifdef ASG_TT_BLANKING_EN
      if (BIN_CNT < BIN_W'(BLANK_BINS)) begin
         gen_next = 1'b0;
      end
`endif
   end

   // Sweep FSM and range bin counter; a trigger restarts and beats a same-cycle tick.
   always_ff @(posedge SYS_CLK or negedge SYS_RESETN) begin
      if (!SYS_RESETN) begin
         state   <= ST_IDLE;
         BIN_CNT <= '0;
         RETRIG  <= 1'b0;
      end else begin
         RETRIG <= 1'b0;
         if (!EN) begin
            state   <= ST_IDLE;
            BIN_CNT <= '0;
         end else if (RADAR_TRIG_PE) begin
            RETRIG  <= (state == ST_SWEEP);
            state   <= ST_SWEEP;
            BIN_CNT <= '0;
         end else if ((state == ST_SWEEP) && USEC_PE) begin
            if (last_bin) begin
               state   <= ST_IDLE;
               BIN_CNT <= '0;
            end else begin
               BIN_CNT <= BIN_CNT + 1'b1;
            end
         end
      end
   end

   // Register the video one clock behind the bin it describes.
   always_ff @(posedge SYS_CLK or negedge SYS_RESETN) begin
      if (!SYS_RESETN) begin
         GEN_SIGNAL <= 1'b0;
      end else begin
         GEN_SIGNAL <= gen_next;
      end
   end

   // Commit request is held until a trigger is accepted and consumes it.
   always_ff @(posedge SYS_CLK or negedge SYS_RESETN) begin
      if (!SYS_RESETN) begin
         COMMIT_PENDING <= 1'b0;
      end else if (copy_now) begin
         COMMIT_PENDING <= 1'b0;
      end else if (cfg.CFG_COMMIT) begin
         COMMIT_PENDING <= 1'b1;
      end
   end

   // Shadow table accepts writes at any time.
   always_ff @(posedge SYS_CLK or negedge SYS_RESETN) begin
      if (!SYS_RESETN) begin
         for (int i = 0; i < NUM_TARGETS; i++) begin
            shadow_tbl[i] <= '0;
         end
      end else if (cfg.CFG_WE) begin
         for (int i = 0; i < NUM_TARGETS; i++) begin
            if (cfg.CFG_ADDR == ADDR_W'(i)) begin
               shadow_tbl[i] <= new_entry;
            end
         end
      end
   end

   // Active table loads from shadow on commit; a same-cycle write is forwarded in.
   always_ff @(posedge SYS_CLK or negedge SYS_RESETN) begin
      if (!SYS_RESETN) begin
         for (int i = 0; i < NUM_TARGETS; i++) begin
            active_tbl[i] <= '0;
         end
      end else if (copy_now) begin
         for (int i = 0; i < NUM_TARGETS; i++) begin
            if (cfg.CFG_WE && (cfg.CFG_ADDR == ADDR_W'(i))) begin
               active_tbl[i] <= new_entry;
            end else begin
               active_tbl[i] <= shadow_tbl[i];
            end
         end
      end
   end

endmodule

// File: tb/tb_asg_target_table_generator.sv
// tb/tb_asg_target_table_generator.sv - directed self-checking bench for the target table generator
module tb_asg_target_table_generator;

   localparam int NT    = 8;
   localparam int BINS  = 3200;
   localparam int BIN_W = 12;

   logic              SYS_CLK;
   logic              SYS_RESETN;
   logic              RADAR_TRIG_PE;
   logic              USEC_PE;
   logic              EN;
   logic              GEN_SIGNAL;
   logic              SWEEP_ACTIVE;
   logic [BIN_W-1:0]  BIN_CNT;
   logic              COMMIT_PENDING;
   logic              RETRIG;

   asg_target_table_generator_if #(.ADDR_W(3), .BIN_W(BIN_W), .WIDTH_W(4)) cfg_if ();

   asg_target_table_generator dut (
      .SYS_CLK        (SYS_CLK),
      .SYS_RESETN     (SYS_RESETN),
      .RADAR_TRIG_PE  (RADAR_TRIG_PE),
      .USEC_PE        (USEC_PE),
      .EN             (EN),
      .cfg            (cfg_if),
      .GEN_SIGNAL     (GEN_SIGNAL),
      .SWEEP_ACTIVE   (SWEEP_ACTIVE),
      .BIN_CNT        (BIN_CNT),
      .COMMIT_PENDING (COMMIT_PENDING),
      .RETRIG         (RETRIG)
   );

   initial SYS_CLK = 1'b0;
   always #5 SYS_CLK = ~SYS_CLK;

   int tests = 0;
   int fails = 0;
   int cur_bin = 0;

   int  sh_s [NT];
   int  sh_w [NT];
   int  ac_s [NT];
   int  ac_w [NT];
   bit  pend;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic bit exp_gen(input int b);
      bit r;
      r = 1'b0;
      for (int i = 0; i < NT; i++) begin
         if (ac_w[i] != 0 && b >= ac_s[i] && b < ac_s[i] + ac_w[i] && b < BINS) r = 1'b1;
      end
`ifdef ASG_TT_BLANKING_EN
      if (b < 10) r = 1'b0;
`endif
      return r;
   endfunction

   task automatic cfg_write(input int a, input int s, input int w);
      cfg_if.CFG_WE    = 1'b1;
      cfg_if.CFG_ADDR  = 3'(a);
      cfg_if.CFG_START = 12'(s);
      cfg_if.CFG_WIDTH = 4'(w);
      @(negedge SYS_CLK);
      cfg_if.CFG_WE = 1'b0;
      sh_s[a] = s;
      sh_w[a] = w;
   endtask

   task automatic commit();
      cfg_if.CFG_COMMIT = 1'b1;
      @(negedge SYS_CLK);
      cfg_if.CFG_COMMIT = 1'b0;
      pend = 1'b1;
   endtask

   task automatic trigger(input bit exp_retrig);
      RADAR_TRIG_PE = 1'b1;
      @(negedge SYS_CLK);
      RADAR_TRIG_PE     = 1'b0;
      USEC_PE           = 1'b0;
      cfg_if.CFG_WE     = 1'b0;
      cfg_if.CFG_COMMIT = 1'b0;
      if (pend) begin
         for (int i = 0; i < NT; i++) begin
            ac_s[i] = sh_s[i];
            ac_w[i] = sh_w[i];
         end
      end
      pend    = 1'b0;
      cur_bin = 0;
      check("trig_retrig", 32'(RETRIG), 32'(exp_retrig));
      check("trig_bin", 32'(BIN_CNT), 0);
      check("trig_sweep", 32'(SWEEP_ACTIVE), 1);
      check("trig_pend", 32'(COMMIT_PENDING), 0);
      @(negedge SYS_CLK);
      check("trig_retrig_clr", 32'(RETRIG), 0);
      check("trig_gen0", 32'(GEN_SIGNAL), 32'(exp_gen(0)));
   endtask

   task automatic usec();
      USEC_PE = 1'b1;
      @(negedge SYS_CLK);
      USEC_PE = 1'b0;
      @(negedge SYS_CLK);
   endtask

   task automatic run_to(input int target);
      while (cur_bin < target) begin
         usec();
         cur_bin++;
         check("sweep_bin", 32'(BIN_CNT), 32'(cur_bin));
         check($sformatf("gen_bin%0d", cur_bin), 32'(GEN_SIGNAL), 32'(exp_gen(cur_bin)));
      end
   endtask

   task automatic finish_sweep();
      usec();
      cur_bin = 0;
      check("end_sweep", 32'(SWEEP_ACTIVE), 0);
      check("end_bin", 32'(BIN_CNT), 0);
      check("end_gen", 32'(GEN_SIGNAL), 0);
   endtask

   initial begin
      SYS_RESETN        = 1'b0;
      RADAR_TRIG_PE     = 1'b0;
      USEC_PE           = 1'b0;
      EN                = 1'b1;
      cfg_if.CFG_WE     = 1'b0;
      cfg_if.CFG_ADDR   = '0;
      cfg_if.CFG_START  = '0;
      cfg_if.CFG_WIDTH  = '0;
      cfg_if.CFG_COMMIT = 1'b0;
      pend = 1'b0;
      for (int i = 0; i < NT; i++) begin
         sh_s[i] = 0; sh_w[i] = 0; ac_s[i] = 0; ac_w[i] = 0;
      end
      repeat (3) @(negedge SYS_CLK);

      check("rst_gen", 32'(GEN_SIGNAL), 0);
      check("rst_sweep", 32'(SWEEP_ACTIVE), 0);
      check("rst_bin", 32'(BIN_CNT), 0);
      check("rst_pend", 32'(COMMIT_PENDING), 0);
      check("rst_retrig", 32'(RETRIG), 0);
      SYS_RESETN = 1'b1;
      @(negedge SYS_CLK);

      // Eight 3-bin targets every 400 bins, full sweep.
      for (int k = 0; k < NT; k++) cfg_write(k, 100 + 400 * k, 3);
      commit();
      check("pend_set", 32'(COMMIT_PENDING), 1);
      trigger(1'b0);
      run_to(BINS - 1);
      finish_sweep();

      // Target at the sweep end is truncated, not wrapped.
      cfg_write(0, 3198, 4);
      for (int k = 1; k < NT; k++) cfg_write(k, 0, 0);
      commit();
      trigger(1'b0);
      run_to(BINS - 1);
      finish_sweep();
      check("idle_gen", 32'(GEN_SIGNAL), 0);

      // Retrigger mid-sweep, then trigger together with a tick.
      trigger(1'b0);
      run_to(1500);
      trigger(1'b1);
      run_to(5);
      USEC_PE = 1'b1;
      trigger(1'b1);

      // Shadow write without commit leaves the active table alone.
      cfg_write(1, 200, 2);
      run_to(205);
      check("no_commit_pend", 32'(COMMIT_PENDING), 0);
      commit();
      check("pend_set2", 32'(COMMIT_PENDING), 1);
      trigger(1'b1);
      run_to(800);

      // Asynchronous reset mid-sweep.
      commit();
      check("pend_before_rst", 32'(COMMIT_PENDING), 1);
      #2 SYS_RESETN = 1'b0;
      #1;
      check("arst_gen", 32'(GEN_SIGNAL), 0);
      check("arst_sweep", 32'(SWEEP_ACTIVE), 0);
      check("arst_bin", 32'(BIN_CNT), 0);
      check("arst_pend", 32'(COMMIT_PENDING), 0);
      check("arst_retrig", 32'(RETRIG), 0);
      @(negedge SYS_CLK);
      SYS_RESETN = 1'b1;
      pend = 1'b0;
      for (int i = 0; i < NT; i++) begin
         sh_s[i] = 0; sh_w[i] = 0; ac_s[i] = 0; ac_w[i] = 0;
      end
      repeat (3) usec();
      check("post_rst_sweep", 32'(SWEEP_ACTIVE), 0);
      check("post_rst_bin", 32'(BIN_CNT), 0);

      // Commit and write coinciding with the accepted trigger.
      cfg_if.CFG_WE     = 1'b1;
      cfg_if.CFG_ADDR   = 3'd2;
      cfg_if.CFG_START  = 12'd50;
      cfg_if.CFG_WIDTH  = 4'd1;
      cfg_if.CFG_COMMIT = 1'b1;
      sh_s[2] = 50;
      sh_w[2] = 1;
      pend = 1'b1;
      trigger(1'b0);
      run_to(50);
      check("coinc_gen50", 32'(GEN_SIGNAL), 1);

      // Disable forces idle and blocks triggers.
      EN = 1'b0;
      @(negedge SYS_CLK);
      check("dis_gen", 32'(GEN_SIGNAL), 0);
      check("dis_sweep", 32'(SWEEP_ACTIVE), 0);
      check("dis_bin", 32'(BIN_CNT), 0);
      RADAR_TRIG_PE = 1'b1;
      @(negedge SYS_CLK);
      RADAR_TRIG_PE = 1'b0;
      check("dis_trig_sweep", 32'(SWEEP_ACTIVE), 0);
      check("dis_trig_retrig", 32'(RETRIG), 0);
      EN = 1'b1;
      @(negedge SYS_CLK);

      // Entry starting inside the near-range blanking zone.
      cfg_write(2, 0, 0);
      cfg_write(3, 5, 10);
      commit();
      trigger(1'b0);
      run_to(20);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
